// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synthesizer pipeline stages.
//   NOTE_NUM        number of selectable notes (C4..C5)
//   NOTE_IDX_W      width of a note index
//   NOTE_FREQ_HZ    note frequencies in Hz, index 0 = C4
//   half_period()   clock cycles per half period of a note, truncated
//   tone_state_e    tone generator FSM states
//   tone_ctrl_t     registered tone generator state (FSM state + outputs),
//                   kept as one struct so checkers can bind to it directly
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int NOTE_NUM   = 8;
    localparam int NOTE_IDX_W = 3;

    // C4, D4, E4, F4, G4, A4, B4, C5
    localparam int NOTE_FREQ_HZ [NOTE_NUM] = '{262, 294, 330, 349, 392, 440, 494, 523};

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } tone_state_e;

    typedef struct packed {
        tone_state_e           state;
        logic                  snd;
        logic [NOTE_IDX_W-1:0] note;
    } tone_ctrl_t;

    function automatic int half_period(input int clk_hz, input int idx);
        return clk_hz / (2 * NOTE_FREQ_HZ[idx]);
    endfunction

    function automatic int max_half_period(input int clk_hz);
        int m;
        m = 0;
        for (int i = 0; i < NOTE_NUM; i++) begin
            if (half_period(clk_hz, i) > m) begin
                m = half_period(clk_hz, i);
            end
        end
        return m;
    endfunction

    function automatic int min_half_period(input int clk_hz);
        int m;
        m = half_period(clk_hz, 0);
        for (int i = 1; i < NOTE_NUM; i++) begin
            if (half_period(clk_hz, i) < m) begin
                m = half_period(clk_hz, i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// -----------------------------------------------------------------------------
// onehot_enc
// Combinational lowest-set-bit encoder, 8 -> 3 plus a nonzero flag.
// A vector with several bits set is tolerated: the lowest index wins.
//   onehot  in  8  one-hot (or multi-hot) select vector
//   idx     out 3  index of the lowest set bit, 0 when onehot is zero
//   nz      out 1  high when any bit of onehot is set
// -----------------------------------------------------------------------------
module onehot_enc
    import synth_pkg::*;
(
    input  logic [NOTE_NUM-1:0]   onehot,
    output logic [NOTE_IDX_W-1:0] idx,
    output logic                  nz
);

    always_comb begin
        idx = '0;
        // Scan from the top down so the lowest set bit is the last write.
        for (int i = NOTE_NUM - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = NOTE_IDX_W'(i);
            end
        end
        nz = |onehot;
    end

endmodule

// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Square-wave tone generator fed by the note decoder. Produces a 50% duty
// square wave at the frequency of the selected note. Note changes and releases
// only take effect on half-period boundaries, so no runt pulse is emitted.
//   CLK_HZ    system clock frequency in Hz (derives per-note half periods)
//   CNT_W     half-period counter width, must hold the largest HALF_PER - 1
//   clk_i     in  1  system clock
//   rst_i     in  1  asynchronous active-high reset
//   dig_i     in  8  one-hot note select, all zero = no note
//   snd_o     out 1  square-wave audio output
//   active_o  out 1  high while a tone is playing
//   note_o    out 3  index of the note playing, 0 when idle
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module tone_gen
    import synth_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NOTE_NUM-1:0]   dig_i,
    output logic                  snd_o,
    output logic                  active_o,
    output logic [NOTE_IDX_W-1:0] note_o
);

    localparam int MAX_HP = max_half_period(CLK_HZ);
    localparam int MIN_HP = min_half_period(CLK_HZ);

    // Elaboration-time sanity checks on the derived half periods.
    if (MIN_HP < 1) begin : g_hp_too_small
        $error("tone_gen: CLK_HZ too low, a note half period is below one cycle");
    end
    if (((MAX_HP - 1) >> CNT_W) != 0) begin : g_cnt_too_narrow
        $error("tone_gen: CNT_W cannot hold the largest half period minus one");
    end

    // Reload values (HALF_PER - 1) per note, fixed at elaboration.
    logic [CNT_W-1:0] half_m1 [NOTE_NUM];

    for (genvar g = 0; g < NOTE_NUM; g++) begin : g_half
        assign half_m1[g] = CNT_W'(half_period(CLK_HZ, g) - 1);
    end

    // Input register: every decision is taken on dig_r.
    logic [NOTE_NUM-1:0] dig_r;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dig_r <= '0;
        end else begin
            dig_r <= dig_i;
        end
    end

    logic [NOTE_IDX_W-1:0] sel;
    logic                  sel_nz;

    onehot_enc u_enc (
        .onehot (dig_r),
        .idx    (sel),
        .nz     (sel_nz)
    );

    // FSM state and registered outputs.
    tone_ctrl_t       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q <= '{state: IDLE, snd: 1'b0, note: '0};
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;

        unique case (ctrl_q.state)
            IDLE: begin
                ctrl_d.snd  = 1'b0;
                ctrl_d.note = '0;
                cnt_d       = '0;
                if (sel_nz) begin
                    // Start with a high phase of the selected note.
                    ctrl_d.state = PLAY;
                    ctrl_d.snd   = 1'b1;
                    ctrl_d.note  = sel;
                    cnt_d        = half_m1[sel];
                end
            end

            PLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (sel_nz) begin
                    // Half-period boundary: flip and reload from whatever
                    // note is selected now, so a change lands on the next
                    // half phase and a momentary zero earlier is ignored.
                    ctrl_d.snd  = ~ctrl_q.snd;
                    ctrl_d.note = sel;
                    cnt_d       = half_m1[sel];
                end else begin
                    // Released at the boundary: stop without a new phase.
                    ctrl_d.state = IDLE;
                    ctrl_d.snd   = 1'b0;
                    ctrl_d.note  = '0;
                    cnt_d        = '0;
                end
            end

            default: begin
                ctrl_d = '{state: IDLE, snd: 1'b0, note: '0};
                cnt_d  = '0;
            end
        endcase
    end

    assign snd_o    = ctrl_q.snd;
    assign active_o = (ctrl_q.state == PLAY);
    assign note_o   = ctrl_q.note;

endmodule

// File: tb/tb_tone_gen.sv
module tb_tone_gen;

  localparam int CLK_HZ = 8800;
  localparam int RUN_W  = 12;  // {level, note[2:0], length[7:0]}

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] dig_i = '0;
  logic       snd_o;
  logic       active_o;
  logic [2:0] note_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Half periods at CLK_HZ = 8800: C4..C5
  int hp_tab [8] = '{16, 14, 13, 12, 11, 10, 8, 8};

  logic [RUN_W-1:0] exp_q[$];
  logic [RUN_W-1:0] obs_q[$];

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  tone_gen #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (17)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .dig_i    (dig_i),
    .snd_o    (snd_o),
    .active_o (active_o),
    .note_o   (note_o)
  );

  // ---------------------------------------------------------------- monitor
  // Collects runs of constant snd_o while active_o is high.
  logic       in_run = 1'b0;
  logic       run_lvl = 1'b0;
  logic [2:0] run_note = '0;
  logic [7:0] run_len = '0;

  always @(negedge clk) begin
    if (active_o) begin
      if (in_run && snd_o == run_lvl) begin
        run_len = run_len + 8'd1;
      end else begin
        if (in_run) obs_q.push_back({run_lvl, run_note, run_len});
        in_run   = 1'b1;
        run_lvl  = snd_o;
        run_note = note_o;
        run_len  = 8'd1;
      end
    end else if (in_run) begin
      obs_q.push_back({run_lvl, run_note, run_len});
      in_run = 1'b0;
    end
  end

  function automatic logic [RUN_W-1:0] mk_run(input logic lvl, input int note, input int len);
    return {lvl, 3'(note), 8'(len)};
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #1;
    n_tests++;
    if ({snd_o, active_o, note_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {snd_o, active_o, note_o});
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if ({snd_o, active_o, note_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 00000", {snd_o, active_o, note_o});
    end
  endtask

  task automatic test_basic();
    logic [RUN_W-1:0] e, o;
    @(negedge clk);
    dig_i = 8'b0010_0000;
    for (int p = 0; p < 10; p++) exp_q.push_back(mk_run(p % 2 == 0, 5, 10));
    @(posedge clk); #1;
    n_tests++;
    if ({snd_o, active_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_latency_early: got %b expected 00", {snd_o, active_o});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({snd_o, active_o, note_o} !== {1'b1, 1'b1, 3'd5}) begin
      n_fail++;
      $display("FAIL basic_start: got %b expected 11101", {snd_o, active_o, note_o});
    end
    repeat (94) @(negedge clk);
    dig_i = '0;  // mid low phase of the 5th period
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_run_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_run: got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                 o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != 0 || {snd_o, active_o, note_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL basic_quiet_after_release: got runs=%0d outs=%b expected runs=0 outs=00000",
               obs_q.size(), {snd_o, active_o, note_o});
    end
    obs_q.delete();
  endtask

  task automatic test_note_change();
    logic [RUN_W-1:0] e, o;
    @(negedge clk);
    dig_i = 8'b0010_0000;
    repeat (5) @(negedge clk);
    dig_i = 8'b0000_0001;  // 4th cycle of the first high phase
    exp_q.push_back(mk_run(1'b1, 5, 10));
    exp_q.push_back(mk_run(1'b0, 0, 16));
    exp_q.push_back(mk_run(1'b1, 0, 16));
    repeat (30) @(negedge clk);
    dig_i = '0;
    repeat (40) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL change_run_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL change_run: got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                 o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_release();
    logic [RUN_W-1:0] e, o;
    @(negedge clk);
    dig_i = 8'b0010_0000;
    for (int p = 0; p < 3; p++) exp_q.push_back(mk_run(p % 2 == 0, 5, 10));
    repeat (25) @(negedge clk);
    dig_i = '0;  // mid second high phase
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL release_run_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL release_run: got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                 o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != 0 || {snd_o, active_o, note_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL release_quiet: got runs=%0d outs=%b expected runs=0 outs=00000",
               obs_q.size(), {snd_o, active_o, note_o});
    end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    logic [RUN_W-1:0] e, o;
    @(negedge clk);
    dig_i = 8'b0010_0000;
    for (int p = 0; p < 6; p++) exp_q.push_back(mk_run(p % 2 == 0, 5, 10));
    repeat (13) @(negedge clk);
    dig_i = '0;  // 3-cycle dropout inside the first low phase
    repeat (3) @(negedge clk);
    dig_i = 8'b0010_0000;
    repeat (39) @(negedge clk);
    dig_i = '0;
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL glitch_run_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL glitch_run: got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                 o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_non_onehot();
    logic [RUN_W-1:0] e, o;
    @(negedge clk);
    dig_i = 8'b1001_0100;
    for (int p = 0; p < 4; p++) exp_q.push_back(mk_run(p % 2 == 0, 2, 13));
    repeat (45) @(negedge clk);
    dig_i = '0;
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL multihot_run_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL multihot_run: got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                 o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [RUN_W-1:0] e, o;
    @(negedge clk);
    dig_i = 8'b0010_0000;
    exp_q.push_back(mk_run(1'b1, 5, 10));
    exp_q.push_back(mk_run(1'b0, 5, 10));
    repeat (15) @(negedge clk);
    dig_i = '0;
    repeat (6) @(negedge clk);
    // Lands one cycle too late to hold the tone: release, then restart as C5.
    dig_i = 8'b1000_0000;
    exp_q.push_back(mk_run(1'b1, 7, 8));
    exp_q.push_back(mk_run(1'b0, 7, 8));
    repeat (12) @(negedge clk);
    dig_i = '0;
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_run_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_run: got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                 o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    logic [RUN_W-1:0] e, o;
    logic [7:0] dig;
    int sel, hp, phases, j;
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      dig = 8'($urandom_range(1, 255));
      sel = 0;
      for (int b = 7; b >= 0; b--) if (dig[b]) sel = b;
      hp = hp_tab[sel];
      phases = $urandom_range(1, 5);
      j = (phases - 1) * hp + $urandom_range(1, hp);
      for (int p = 0; p < phases; p++) exp_q.push_back(mk_run(p % 2 == 0, sel, hp));
      dig_i = dig;
      repeat (j) @(negedge clk);
      dig_i = '0;
      repeat (40) @(negedge clk);
      #1;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL random_run_count: dig=%b got %0d expected %0d", dig, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL random_run: dig=%b got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                   dig, o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
        end
      end
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_tone();
    logic [RUN_W-1:0] e, o;
    @(negedge clk);
    dig_i = 8'b0010_0000;
    repeat (5) @(negedge clk);
    #2;
    rst_i = 1'b1;  // between edges, inside the first high phase
    #1;
    n_tests++;
    if ({snd_o, active_o, note_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b expected 00000", {snd_o, active_o, note_o});
    end
    @(negedge clk); #1;
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    exp_q.push_back(mk_run(1'b1, 5, 10));
    exp_q.push_back(mk_run(1'b0, 5, 10));
    @(posedge clk); #1;
    n_tests++;
    if ({snd_o, active_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_restart_early: got %b expected 00", {snd_o, active_o});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({snd_o, active_o, note_o} !== {1'b1, 1'b1, 3'd5}) begin
      n_fail++;
      $display("FAIL rst_restart: got %b expected 11101", {snd_o, active_o, note_o});
    end
    repeat (14) @(negedge clk);
    dig_i = '0;
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_run_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rst_run: got lvl=%0d note=%0d len=%0d expected lvl=%0d note=%0d len=%0d",
                 o[11], o[10:8], o[7:0], e[11], e[10:8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_basic();
    test_note_change();
    test_release();
    test_glitch();
    test_non_onehot();
    test_back_to_back();
    test_random();
    test_reset_mid_tone();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
